sap_datapath: RTL and testbench
===============================

# sap_datapath

Datapath side of the 8-bit SAP CPU control interface. It receives the control word that the sequencer issues each cycle and carries it out. The block contains:
- the shared 8-bit bus,
- the PC, MAR, IR, A, B and OUT registers,
- the adder/subtractor with its zero and carry flags,
- a 16-byte program RAM.

It returns `opcode`, `zero` and `carry` to the sequencer, which closes the fetch/execute loop.

## Interface
Parameters:
- `DATA_W`, 8, bus, register and RAM word width.
- `ADDR_W`, 4, PC, MAR and RAM address width. Also the width of the IR operand field.

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN, aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN`  in  1 each  control word, same meaning as the sequencer outputs.
- `prog_wen`  in  1  external RAM write strobe, used for program loading.
- `prog_addr`  in  ADDR_W  program-load address.
- `prog_data`  in  DATA_W  program-load data.
- `opcode`  out  4  `IR[7:4]`.
- `zero`  out  1  registered zero flag.
- `carry`  out  1  registered carry flag.
- `out_value`  out  DATA_W  OUT register.
- `bus`  out  DATA_W  current bus value (combinational, for debug).
- `pc`  out  ADDR_W  program counter.
- `halted`  out  1  sticky halt state.
- `bus_conflict`  out  1  more than one bus driver is enabled this cycle.

## Operation
Bus, combinational:
- The bus is the bitwise OR of every enabled driver; it is 0 when no driver is enabled.
- Drivers: `pcREN` drives `{0, PC}`; `ramREN` drives `RAM[MAR]` (asynchronous read); `iREN` drives `{0, IR[3:0]}`; `aREN` drives A; `aluREN` drives the ALU result.
- `bus_conflict` = 1 when two or more of these five enables are high.

ALU, combinational:
- 9-bit sum = A + (sub ? ~B : B) + sub.
- Result = sum[7:0]; carry-out = sum[8].
- For SUB this gives carry = 1 when A ≥ B (unsigned).

Registered writers, applied at the rising edge:
- `addressWEN`: MAR ← bus[3:0].
- `iWEN`: IR ← bus.
- `aWEN`: A ← bus.
- `bWEN`: B ← bus.
- `outputWEN`: OUT ← bus.
- `ramWEN`: RAM[MAR] ← bus.
- `flagWEN`: carry ← carry-out and zero ← (result == 0). Both flags are updated together; otherwise they hold.

PC:
- `jump` loads PC ← bus[3:0].
- Otherwise `pcEN` increments PC modulo 16 (15 → 0).
- `jump` has priority over `pcEN` when both are high.

Simultaneous read and write:
- Registers may read and write in the same cycle. For example, `aluREN`+`aWEN` uses the old A and B values; the new A is visible next cycle.

Halt:
- `halted` is set at the edge where `halt` = 1. It stays set until `nRST` is asserted.
- While `halt` or `halted` is high, all register, flag, PC and `ramWEN` writes are suppressed. This includes the cycle in which `halt` is first asserted.

Program load:
- `prog_wen` writes `RAM[prog_addr]` ← `prog_data`, whether or not the core is halted.
- If `prog_wen` and `ramWEN` are both high in the same cycle, `prog_wen` wins and the `ramWEN` write is dropped.

Reset (`nRST` low, asynchronous, including mid-instruction):
- PC, MAR, IR, A, B, OUT, zero, carry and `halted` all go to 0.
- RAM contents are not reset.
- Consequences: `opcode` = 0, `out_value` = 0, `pc` = 0, `bus` = 0 while no driver is enabled.

## Timing
- One control word per cycle. Writes become visible on outputs one cycle after the edge.
- RAM read latency is 0 cycles (combinational from MAR). RAM write latency is 1 cycle.
- `opcode`, `zero` and `carry` are registered outputs, so the sequencer sees the flags from an ADD/SUB at its next decode step.
- `bus` and `bus_conflict` are purely combinational from the control inputs and register state.
- No handshake; the sequencer owns all timing.

## Structure
- Shared package `sap_pkg`:
  - `DATA_W`, `ADDR_W`, `RAM_DEPTH`=16;
  - opcode enum: NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15;
  - a packed `ctrl_word_t` struct for the 16 control bits, shared with the sequencer.
- One sub-module, `sap_ram16x8`:
  - asynchronous read, synchronous write;
  - two write ports, with program-load priority;
  - no reset.
- Bus mux, ALU and register file live in `sap_datapath` itself.

## Test plan
- **LDA:** preload RAM[14]=0x2A, IR=0x1E. Cycle 1: `iREN`+`addressWEN`. Cycle 2: `ramREN`+`aWEN`. Expect MAR=14 then A=0x2A, with `bus_conflict`=0 throughout.
- **ADD with carry:** A=0xF0, B=0x20, `aluREN`+`aWEN`+`flagWEN` with `sub`=0. Expect A=0x10, carry=1, zero=0.
- **SUB to zero:** A=0x07, B=0x07, `sub`=1 with the same strobes. Expect A=0x00, zero=1, carry=1. Then repeat with A=0x03, B=0x05: expect A=0xFE, carry=0.
- **PC control:**
  - PC=15 with `pcEN`: expect PC=0.
  - PC=3 with `pcEN`+`jump` and IR=0x6A, `iREN` on: expect PC=10.
- **Halt:** assert `halt` together with `aWEN` (bus=0x55). Expect A unchanged and `halted`=1. Further `pcEN` pulses leave PC unchanged. `prog_wen` still writes RAM. `nRST` pulse clears `halted` and all registers while RAM keeps its data.
- **Conflict and priority:** `aREN`+`pcREN` with A=0x80, PC=5: expect bus=0x85 and `bus_conflict`=1. `prog_wen`+`ramWEN` to the same address: expect the `prog_data` value in RAM.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: constants, opcode encoding and control-word layout shared by the
// SAP datapath and its sequencer.
//   DATA_W    - bus, register and RAM word width
//   ADDR_W    - PC, MAR, RAM address and IR operand width
//   RAM_DEPTH - number of program RAM words
package sap_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEPTH = 16;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    // One bit per sequencer strobe; field order matches the sequencer output.
    typedef struct packed {
        logic halt;
        logic addressWEN;
        logic ramWEN;
        logic ramREN;
        logic iWEN;
        logic iREN;
        logic aWEN;
        logic aREN;
        logic aluREN;
        logic sub;
        logic bWEN;
        logic outputWEN;
        logic pcEN;
        logic pcREN;
        logic jump;
        logic flagWEN;
    } ctrl_word_t;

endpackage

// File: rtl/sap_datapath_if.sv
// sap_datapath_if: sequencer <-> datapath connection.
//   master (sequencer / loader): drives the 16 control strobes and the
//          program-load port, receives opcode, zero and carry.
//   slave  (datapath): the reverse direction.
interface sap_datapath_if #(
    parameter int DATA_W = sap_pkg::DATA_W,
    parameter int ADDR_W = sap_pkg::ADDR_W
) ();

    logic              halt;
    logic              addressWEN;
    logic              ramWEN;
    logic              ramREN;
    logic              iWEN;
    logic              iREN;
    logic              aWEN;
    logic              aREN;
    logic              aluREN;
    logic              sub;
    logic              bWEN;
    logic              outputWEN;
    logic              pcEN;
    logic              pcREN;
    logic              jump;
    logic              flagWEN;

    logic              prog_wen;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    logic [3:0]        opcode;
    logic              zero;
    logic              carry;

    modport master (
        output halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN,
               prog_wen, prog_addr, prog_data,
        input  opcode, zero, carry
    );

    modport slave (
        input  halt, addressWEN, ramWEN, ramREN, iWEN, iREN, aWEN, aREN,
               aluREN, sub, bWEN, outputWEN, pcEN, pcREN, jump, flagWEN,
               prog_wen, prog_addr, prog_data,
        output opcode, zero, carry
    );

endinterface

// File: rtl/sap_ram16x8.sv
// sap_ram16x8: program/data RAM, asynchronous read, synchronous write,
// no reset.
//   clk                           - write clock
//   load_wen/load_addr/load_data  - program-load write port (wins on collision)
//   wen/waddr/wdata               - CPU write port
//   raddr/rdata                   - combinational read port
module sap_ram16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              load_wen,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // The program loader has priority: a simultaneous CPU write is dropped
    // even when it targets a different address.
    always_ff @(posedge clk) begin
        if (load_wen) begin
            mem[load_addr] <= load_data;
        end else if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 style datapath executing one control word per cycle.
//   CLK, nRST     - clock, asynchronous active-low reset
//   ctl (slave)   - control strobes, program-load port, opcode/zero/carry
//   out_value     - OUT register
//   bus           - combinational bus value (debug)
//   pc            - program counter
//   halted        - sticky halt state
//   bus_conflict  - two or more bus drivers enabled
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = sap_pkg::DATA_W,
    parameter int ADDR_W = sap_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              nRST,
    sap_datapath_if.slave     ctl,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              bus_conflict
);

    // 9-bit add/subtract; subtraction is A + ~B + 1 so carry means A >= B.
    function automatic logic [DATA_W:0] alu_addsub(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              sub);
        logic [DATA_W-1:0] b_op;
        b_op = sub ? ~b : b;
        return {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    endfunction

    ctrl_word_t        cw;
    logic [ADDR_W-1:0] pc_r, mar_r;
    logic [DATA_W-1:0] ir_r, a_r, b_r, out_r;
    logic              zero_r, carry_r, halted_r;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W:0]   alu_sum;
    logic [2:0]        drv_cnt;
    logic              wr_ok;

    always_comb begin
        cw            = '0;
        cw.halt       = ctl.halt;
        cw.addressWEN = ctl.addressWEN;
        cw.ramWEN     = ctl.ramWEN;
        cw.ramREN     = ctl.ramREN;
        cw.iWEN       = ctl.iWEN;
        cw.iREN       = ctl.iREN;
        cw.aWEN       = ctl.aWEN;
        cw.aREN       = ctl.aREN;
        cw.aluREN     = ctl.aluREN;
        cw.sub        = ctl.sub;
        cw.bWEN       = ctl.bWEN;
        cw.outputWEN  = ctl.outputWEN;
        cw.pcEN       = ctl.pcEN;
        cw.pcREN      = ctl.pcREN;
        cw.jump       = ctl.jump;
        cw.flagWEN    = ctl.flagWEN;
    end

    // Writes are blocked from the very edge at which halt is first raised.
    assign wr_ok   = !(cw.halt || halted_r);
    assign alu_sum = alu_addsub(a_r, b_r, cw.sub);

    // Wired-OR bus: overlapping drivers merge rather than resolve.
    always_comb begin
        bus = '0;
        if (cw.pcREN)  bus = bus | {{(DATA_W-ADDR_W){1'b0}}, pc_r};
        if (cw.ramREN) bus = bus | ram_rdata;
        if (cw.iREN)   bus = bus | {{(DATA_W-ADDR_W){1'b0}}, ir_r[ADDR_W-1:0]};
        if (cw.aREN)   bus = bus | a_r;
        if (cw.aluREN) bus = bus | alu_sum[DATA_W-1:0];
    end

    assign drv_cnt = {2'b0, cw.pcREN} + {2'b0, cw.ramREN} + {2'b0, cw.iREN}
                   + {2'b0, cw.aREN} + {2'b0, cw.aluREN};
    assign bus_conflict = (drv_cnt > 3'd1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_r     <= '0;
            mar_r    <= '0;
            ir_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            out_r    <= '0;
            zero_r   <= 1'b0;
            carry_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            if (cw.halt) halted_r <= 1'b1;
            if (wr_ok) begin
                if (cw.addressWEN) mar_r <= bus[ADDR_W-1:0];
                if (cw.iWEN)       ir_r  <= bus;
                if (cw.aWEN)       a_r   <= bus;
                if (cw.bWEN)       b_r   <= bus;
                if (cw.outputWEN)  out_r <= bus;
                if (cw.jump)       pc_r  <= bus[ADDR_W-1:0];
                else if (cw.pcEN)  pc_r  <= pc_r + 1'b1;
                if (cw.flagWEN) begin
                    carry_r <= alu_sum[DATA_W];
                    zero_r  <= (alu_sum[DATA_W-1:0] == '0);
                end
            end
        end
    end

    sap_ram16x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (CLK),
        .load_wen  (ctl.prog_wen),
        .load_addr (ctl.prog_addr),
        .load_data (ctl.prog_data),
        .wen       (cw.ramWEN && wr_ok),
        .waddr     (mar_r),
        .wdata     (bus),
        .raddr     (mar_r),
        .rdata     (ram_rdata)
    );

    assign ctl.opcode = ir_r[DATA_W-1 -: 4];
    assign ctl.zero   = zero_r;
    assign ctl.carry  = carry_r;
    assign out_value  = out_r;
    assign pc         = pc_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_sap_datapath.sv
module tb_sap_datapath;

    logic       CLK;
    logic       nRST;
    logic [7:0] out_value;
    logic [7:0] bus;
    logic [3:0] pc;
    logic       halted;
    logic       bus_conflict;

    int         vecs;
    int         miss;
    logic [3:0] mar_cur;
    logic [7:0] rd;

    localparam int S_A   = 0;
    localparam int S_B   = 1;
    localparam int S_IR  = 2;
    localparam int S_MAR = 3;
    localparam int S_OUT = 4;

    sap_datapath_if cif ();

    sap_datapath dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ctl          (cif),
        .out_value    (out_value),
        .bus          (bus),
        .pc           (pc),
        .halted       (halted),
        .bus_conflict (bus_conflict)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clr();
        cif.halt = 0; cif.addressWEN = 0; cif.ramWEN = 0; cif.ramREN = 0;
        cif.iWEN = 0; cif.iREN = 0; cif.aWEN = 0; cif.aREN = 0;
        cif.aluREN = 0; cif.sub = 0; cif.bWEN = 0; cif.outputWEN = 0;
        cif.pcEN = 0; cif.pcREN = 0; cif.jump = 0; cif.flagWEN = 0;
        cif.prog_wen = 0; cif.prog_addr = '0; cif.prog_data = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        clr();
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        cif.prog_wen = 1; cif.prog_addr = a; cif.prog_data = d;
        tick();
    endtask

    // Route a value into a register through the RAM word currently at MAR.
    task automatic load(input int sel, input logic [7:0] v);
        prog(mar_cur, v);
        cif.ramREN = 1;
        case (sel)
            S_A:     cif.aWEN = 1;
            S_B:     cif.bWEN = 1;
            S_IR:    cif.iWEN = 1;
            S_MAR:   cif.addressWEN = 1;
            default: cif.outputWEN = 1;
        endcase
        tick();
        if (sel == S_MAR) mar_cur = v[3:0];
    endtask

    task automatic peek_a(output logic [7:0] v);
        cif.aREN = 1; #1; v = bus; clr(); #1;
    endtask

    task automatic peek_ram(output logic [7:0] v);
        cif.ramREN = 1; #1; v = bus; clr(); #1;
    endtask

    task automatic do_reset();
        nRST = 0; #2; nRST = 1; #1;
        mar_cur = '0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (bus !== 8'h00) begin miss++; $display("FAIL rst_bus got %h want 00", bus); end
        vecs++; if (cif.opcode !== 4'h0) begin miss++; $display("FAIL rst_opcode got %h want 0", cif.opcode); end
        vecs++; if (pc !== 4'h0) begin miss++; $display("FAIL rst_pc got %h want 0", pc); end
        vecs++; if (out_value !== 8'h00) begin miss++; $display("FAIL rst_out got %h want 00", out_value); end
        vecs++; if ({cif.zero, cif.carry, halted, bus_conflict} !== 4'b0000) begin miss++; $display("FAIL rst_flags got %b want 0000", {cif.zero, cif.carry, halted, bus_conflict}); end
        cif.pcREN = 1; cif.aREN = 1; #1;
        vecs++; if (bus !== 8'h00) begin miss++; $display("FAIL rst_regs_bus got %h want 00", bus); end
        clr(); #1;
    endtask

    task automatic test_lda();
        prog(4'd14, 8'h2A);
        load(S_IR, 8'h1E);
        vecs++; if (cif.opcode !== 4'h1) begin miss++; $display("FAIL lda_opcode got %h want 1", cif.opcode); end
        cif.iREN = 1; cif.addressWEN = 1; #1;
        vecs++; if (bus !== 8'h0E) begin miss++; $display("FAIL lda_iren_bus got %h want 0e", bus); end
        vecs++; if (bus_conflict !== 1'b0) begin miss++; $display("FAIL lda_conflict1 got %b want 0", bus_conflict); end
        tick();
        mar_cur = 4'd14;
        cif.ramREN = 1; cif.aWEN = 1; #1;
        vecs++; if (bus !== 8'h2A) begin miss++; $display("FAIL lda_ram_bus got %h want 2a", bus); end
        vecs++; if (bus_conflict !== 1'b0) begin miss++; $display("FAIL lda_conflict2 got %b want 0", bus_conflict); end
        tick();
        peek_a(rd);
        vecs++; if (rd !== 8'h2A) begin miss++; $display("FAIL lda_a got %h want 2a", rd); end
        cif.ramREN = 1; cif.outputWEN = 1; tick();
        vecs++; if (out_value !== 8'h2A) begin miss++; $display("FAIL out_reg got %h want 2a", out_value); end
    endtask

    task automatic test_add();
        load(S_A, 8'hF0);
        load(S_B, 8'h20);
        cif.aluREN = 1; cif.aWEN = 1; cif.flagWEN = 1; #1;
        vecs++; if (bus !== 8'h10) begin miss++; $display("FAIL add_bus got %h want 10", bus); end
        tick();
        peek_a(rd);
        vecs++; if (rd !== 8'h10) begin miss++; $display("FAIL add_a got %h want 10", rd); end
        vecs++; if ({cif.carry, cif.zero} !== 2'b10) begin miss++; $display("FAIL add_flags got %b want 10", {cif.carry, cif.zero}); end
    endtask

    task automatic test_sub();
        load(S_A, 8'h07);
        load(S_B, 8'h07);
        cif.aluREN = 1; cif.aWEN = 1; cif.flagWEN = 1; cif.sub = 1; tick();
        peek_a(rd);
        vecs++; if (rd !== 8'h00) begin miss++; $display("FAIL sub0_a got %h want 00", rd); end
        vecs++; if ({cif.carry, cif.zero} !== 2'b11) begin miss++; $display("FAIL sub0_flags got %b want 11", {cif.carry, cif.zero}); end
        load(S_A, 8'h03);
        load(S_B, 8'h05);
        cif.aluREN = 1; cif.aWEN = 1; cif.flagWEN = 1; cif.sub = 1; tick();
        peek_a(rd);
        vecs++; if (rd !== 8'hFE) begin miss++; $display("FAIL subneg_a got %h want fe", rd); end
        vecs++; if ({cif.carry, cif.zero} !== 2'b00) begin miss++; $display("FAIL subneg_flags got %b want 00", {cif.carry, cif.zero}); end
        // 0xFE + 0x05 carries out, but flags must hold without flagWEN.
        cif.aluREN = 1; cif.aWEN = 1; tick();
        peek_a(rd);
        vecs++; if (rd !== 8'h03) begin miss++; $display("FAIL nofl_a got %h want 03", rd); end
        vecs++; if ({cif.carry, cif.zero} !== 2'b00) begin miss++; $display("FAIL nofl_flags got %b want 00", {cif.carry, cif.zero}); end
    endtask

    task automatic test_pc();
        load(S_A, 8'h0F);
        cif.aREN = 1; cif.jump = 1; tick();
        vecs++; if (pc !== 4'hF) begin miss++; $display("FAIL pc_jump15 got %h want f", pc); end
        cif.pcEN = 1; tick();
        vecs++; if (pc !== 4'h0) begin miss++; $display("FAIL pc_wrap got %h want 0", pc); end
        load(S_A, 8'h03);
        cif.aREN = 1; cif.jump = 1; tick();
        load(S_IR, 8'h6A);
        cif.iREN = 1; cif.pcEN = 1; cif.jump = 1; tick();
        vecs++; if (pc !== 4'hA) begin miss++; $display("FAIL pc_jump_prio got %h want a", pc); end
        cif.pcEN = 1; tick();
        vecs++; if (pc !== 4'hB) begin miss++; $display("FAIL pc_inc got %h want b", pc); end
    endtask

    task automatic test_conflict();
        load(S_A, 8'h05);
        cif.aREN = 1; cif.jump = 1; tick();
        load(S_A, 8'h80);
        cif.aREN = 1; cif.pcREN = 1; #1;
        vecs++; if (bus !== 8'h85) begin miss++; $display("FAIL conf_bus got %h want 85", bus); end
        vecs++; if (bus_conflict !== 1'b1) begin miss++; $display("FAIL conf_flag got %b want 1", bus_conflict); end
        cif.pcREN = 0; #1;
        vecs++; if (bus_conflict !== 1'b0) begin miss++; $display("FAIL conf_single got %b want 0", bus_conflict); end
        cif.pcREN = 1; cif.iREN = 1; #1;
        vecs++; if (bus !== 8'h8F) begin miss++; $display("FAIL conf3_bus got %h want 8f", bus); end
        clr();
        cif.aREN = 1; cif.ramWEN = 1; tick();
        peek_ram(rd);
        vecs++; if (rd !== 8'h80) begin miss++; $display("FAIL sta_ram got %h want 80", rd); end
        cif.aREN = 1; cif.ramWEN = 1;
        cif.prog_wen = 1; cif.prog_addr = mar_cur; cif.prog_data = 8'h3C; tick();
        peek_ram(rd);
        vecs++; if (rd !== 8'h3C) begin miss++; $display("FAIL wr_prio got %h want 3c", rd); end
    endtask

    task automatic test_halt();
        load(S_A, 8'h11);
        prog(mar_cur, 8'h55);
        cif.ramREN = 1; cif.aWEN = 1; cif.halt = 1; tick();
        vecs++; if (halted !== 1'b1) begin miss++; $display("FAIL halt_set got %b want 1", halted); end
        peek_a(rd);
        vecs++; if (rd !== 8'h11) begin miss++; $display("FAIL halt_a got %h want 11", rd); end
        cif.pcEN = 1; tick();
        cif.pcEN = 1; tick();
        vecs++; if (pc !== 4'h5) begin miss++; $display("FAIL halt_pc got %h want 5", pc); end
        prog(mar_cur, 8'h99);
        peek_ram(rd);
        vecs++; if (rd !== 8'h99) begin miss++; $display("FAIL halt_prog got %h want 99", rd); end
        cif.aREN = 1; cif.ramWEN = 1; tick();
        peek_ram(rd);
        vecs++; if (rd !== 8'h99) begin miss++; $display("FAIL halt_ramwen got %h want 99", rd); end
        prog(4'd3, 8'h77);
        do_reset();
        vecs++; if ({halted, pc, cif.opcode} !== 9'b0) begin miss++; $display("FAIL hrst_state got %h want 000", {halted, pc, cif.opcode}); end
        vecs++; if (out_value !== 8'h00) begin miss++; $display("FAIL hrst_out got %h want 00", out_value); end
        peek_a(rd);
        vecs++; if (rd !== 8'h00) begin miss++; $display("FAIL hrst_a got %h want 00", rd); end
        load(S_MAR, 8'h03);
        peek_ram(rd);
        vecs++; if (rd !== 8'h77) begin miss++; $display("FAIL hrst_ram got %h want 77", rd); end
    endtask

    initial begin
        vecs = 0;
        miss = 0;
        mar_cur = '0;
        nRST = 0;
        clr();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_lda();
        test_add();
        test_sub();
        test_pc();
        test_conflict();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
